// File: rtl/conv_layer_sequencer_pkg.sv
// rtl/conv_layer_sequencer_pkg.sv - shared types and sizing helpers for the conv layer sequencer
package conv_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_NEXT,
    ST_DONE
  } seq_state_e;

  function automatic int pixels(input int img_size);
    return img_size * img_size;
  endfunction

  function automatic int addr_width_for(input int img_size);
    return (img_size > 1) ? $clog2(img_size * img_size) : 1;
  endfunction

  function automatic int map_width_for(input int num_maps);
    return (num_maps > 1) ? $clog2(num_maps) : 1;
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_pixel_counter.sv
// rtl/conv_layer_sequencer_pixel_counter.sv - wrapping pixel counter with enable, clear and terminal flag
module pixel_counter #(
  parameter int WIDTH = 14,
  parameter int LIMIT = 10816
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             term_o
);

  logic [WIDTH-1:0] count_q, count_d;

  assign term_o  = (count_q == WIDTH'(LIMIT - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = term_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - per-layer feed/drain sequencer across all output feature maps
module conv_layer_sequencer
  import conv_layer_sequencer_pkg::*;
#(
  parameter int IMG_SIZE   = 104,
  parameter int NUM_MAPS   = 64,
  parameter int ADDR_WIDTH = 14,
  parameter int MAP_WIDTH  = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  stall,
  input  logic                  conv_valid_out,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  conv_valid_in,
  output logic [MAP_WIDTH-1:0]  map_sel,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int PIXELS = pixels(IMG_SIZE);

  seq_state_e           state_q;
  logic [MAP_WIDTH-1:0] map_sel_q;
  logic                 wr_full_q;
  logic                 conv_valid_in_q;

  logic                  active;
  logic                  cnt_clr;
  logic                  rd_term;
  logic                  wr_term;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] wr_cnt;

  assign active  = (state_q == ST_FEED) || (state_q == ST_DRAIN);
  assign cnt_clr = !active || abort;
  assign rd_en   = (state_q == ST_FEED) && !stall && !abort;
  // Results beyond the map's pixel count are dropped once the write side is full.
  assign wr_en   = active && conv_valid_out && !wr_full_q;

  pixel_counter #(.WIDTH(ADDR_WIDTH), .LIMIT(PIXELS)) u_rd_cnt (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .clr_i  (cnt_clr),
    .en_i   (rd_en),
    .count_o(rd_cnt),
    .term_o (rd_term)
  );

  pixel_counter #(.WIDTH(ADDR_WIDTH), .LIMIT(PIXELS)) u_wr_cnt (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .clr_i  (cnt_clr),
    .en_i   (wr_en),
    .count_o(wr_cnt),
    .term_o (wr_term)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q         <= ST_IDLE;
      map_sel_q       <= '0;
      wr_full_q       <= 1'b0;
      conv_valid_in_q <= 1'b0;
    end else begin
      conv_valid_in_q <= rd_en;
      if (cnt_clr) begin
        wr_full_q <= 1'b0;
      end else if (wr_en && wr_term) begin
        wr_full_q <= 1'b1;
      end
      if (abort && state_q != ST_IDLE) begin
        state_q   <= ST_IDLE;
        map_sel_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              state_q   <= ST_FEED;
              map_sel_q <= '0;
            end
          end
          ST_FEED: begin
            if (rd_en && rd_term) state_q <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (wr_full_q || (wr_en && wr_term)) state_q <= ST_NEXT;
          end
          ST_NEXT: begin
            if (map_sel_q == MAP_WIDTH'(NUM_MAPS - 1)) begin
              state_q <= ST_DONE;
            end else begin
              map_sel_q <= map_sel_q + 1'b1;
              state_q   <= ST_FEED;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_addr       = rd_cnt;
  assign wr_addr       = wr_cnt;
  assign map_sel       = map_sel_q;
  assign conv_valid_in = conv_valid_in_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb/tb_conv_layer_sequencer.sv - directed self-checking bench for conv_layer_sequencer (4x4, 2 maps)
module tb_conv_layer_sequencer;

  localparam int IMG  = 4;
  localparam int MAPS = 2;
  localparam int AW   = 4;
  localparam int MW   = 1;
  localparam int PIX  = 16;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic          conv_valid_out;
  logic          rd_en, conv_valid_in, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [MW-1:0] map_sel;

  logic       model_en  = 1'b1;
  logic       manual_vo = 1'b0;
  logic [4:0] dp_sr     = '0;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int rd_n = 0, wr_n = 0, done_n = 0, done_cyc = -1;
  logic [AW-1:0] rd_log [64];
  logic [AW-1:0] wr_log [64];
  logic [MW-1:0] rd_map [64];
  logic [MW-1:0] wr_map [64];

  conv_layer_sequencer #(
    .IMG_SIZE(IMG), .NUM_MAPS(MAPS), .ADDR_WIDTH(AW), .MAP_WIDTH(MW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .abort(abort), .stall(stall),
    .conv_valid_out(conv_valid_out), .rd_en(rd_en), .rd_addr(rd_addr),
    .conv_valid_in(conv_valid_in), .map_sel(map_sel), .wr_en(wr_en),
    .wr_addr(wr_addr), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // Datapath stand-in: valid_out follows valid_in by five cycles.
  assign conv_valid_out = model_en ? dp_sr[4] : manual_vo;
  always @(posedge Clk) begin
    cyc   <= cyc + 1;
    dp_sr <= {dp_sr[3:0], conv_valid_in};
  end

  always @(negedge Clk) begin
    if (rd_en && rd_n < 64) begin
      rd_log[rd_n] = rd_addr;
      rd_map[rd_n] = map_sel;
      rd_n++;
    end
    if (wr_en && wr_n < 64) begin
      wr_log[wr_n] = wr_addr;
      wr_map[wr_n] = map_sel;
      wr_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic clear_logs;
    rd_n = 0; wr_n = 0; done_n = 0; done_cyc = -1;
  endtask

  task automatic pulse_start(output int t0);
    @(posedge Clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge Clk);
    #2;
    tests_run++; if (rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %0b want 0", rd_en); end
    tests_run++; if (rd_addr !== 4'd0) begin tests_failed++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    tests_run++; if (conv_valid_in !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_in: got %0b want 0", conv_valid_in); end
    tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
    tests_run++; if (wr_addr !== 4'd0) begin tests_failed++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    tests_run++; if (map_sel !== 1'b0) begin tests_failed++; $display("FAIL reset_map_sel: got %0d want 0", map_sel); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %0b want 0", done); end
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_full_layer;
    int t0;
    model_en = 1'b1;
    clear_logs();
    pulse_start(t0);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL full_busy_t1: got %0b want 1", busy); end
    tests_run++; if (rd_en !== 1'b1) begin tests_failed++; $display("FAIL full_rd_en_t1: got %0b want 1", rd_en); end
    tests_run++; if (rd_addr !== 4'd0) begin tests_failed++; $display("FAIL full_rd_addr_t1: got %0d want 0", rd_addr); end
    tests_run++; if (map_sel !== 1'b0) begin tests_failed++; $display("FAIL full_map_t1: got %0d want 0", map_sel); end
    repeat (23) @(posedge Clk);
    #1;
    tests_run++; if (map_sel !== 1'b1) begin tests_failed++; $display("FAIL full_map_t24: got %0d want 1", map_sel); end
    tests_run++; if (rd_en !== 1'b1 || rd_addr !== 4'd0) begin tests_failed++; $display("FAIL full_map1_first_rd: got en=%0b addr=%0d want en=1 addr=0", rd_en, rd_addr); end
    repeat (30) @(posedge Clk);
    #1;
    tests_run++; if (rd_n !== 2 * PIX) begin tests_failed++; $display("FAIL full_rd_count: got %0d want %0d", rd_n, 2 * PIX); end
    tests_run++; if (wr_n !== 2 * PIX) begin tests_failed++; $display("FAIL full_wr_count: got %0d want %0d", wr_n, 2 * PIX); end
    for (int i = 0; i < 2 * PIX && i < rd_n; i++) begin
      tests_run++; if (rd_log[i] !== AW'(i % PIX) || rd_map[i] !== MW'(i / PIX)) begin tests_failed++; $display("FAIL full_rd_%0d: got addr=%0d map=%0d want addr=%0d map=%0d", i, rd_log[i], rd_map[i], i % PIX, i / PIX); end
    end
    for (int i = 0; i < 2 * PIX && i < wr_n; i++) begin
      tests_run++; if (wr_log[i] !== AW'(i % PIX) || wr_map[i] !== MW'(i / PIX)) begin tests_failed++; $display("FAIL full_wr_%0d: got addr=%0d map=%0d want addr=%0d map=%0d", i, wr_log[i], wr_map[i], i % PIX, i / PIX); end
    end
    tests_run++; if (done_n !== 1) begin tests_failed++; $display("FAIL full_done_count: got %0d want 1", done_n); end
    tests_run++; if (done_cyc !== t0 + 47) begin tests_failed++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc - t0, 47); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL full_busy_end: got %0b want 0", busy); end
  endtask

  task automatic test_stall;
    int t0;
    model_en = 1'b1;
    clear_logs();
    pulse_start(t0);
    @(posedge Clk); #1;
    for (int c = 3; c <= 6; c++) begin
      @(posedge Clk); #1;
      stall = 1'b1;
      #1;
      tests_run++; if (rd_en !== 1'b0) begin tests_failed++; $display("FAIL stall_rd_en_c%0d: got %0b want 0", c, rd_en); end
      tests_run++; if (rd_addr !== 4'd2) begin tests_failed++; $display("FAIL stall_rd_addr_c%0d: got %0d want 2", c, rd_addr); end
    end
    @(posedge Clk); #1;
    stall = 1'b0;
    repeat (50) @(posedge Clk);
    #1;
    tests_run++; if (rd_n !== 2 * PIX) begin tests_failed++; $display("FAIL stall_rd_count: got %0d want %0d", rd_n, 2 * PIX); end
    for (int i = 0; i < 2 * PIX && i < rd_n; i++) begin
      tests_run++; if (rd_log[i] !== AW'(i % PIX)) begin tests_failed++; $display("FAIL stall_rd_%0d: got %0d want %0d", i, rd_log[i], i % PIX); end
    end
    tests_run++; if (wr_n !== 2 * PIX) begin tests_failed++; $display("FAIL stall_wr_count: got %0d want %0d", wr_n, 2 * PIX); end
    tests_run++; if (done_n !== 1) begin tests_failed++; $display("FAIL stall_done_count: got %0d want 1", done_n); end
    tests_run++; if (done_cyc !== t0 + 51) begin tests_failed++; $display("FAIL stall_done_cycle: got %0d want %0d", done_cyc - t0, 51); end
  endtask

  task automatic test_abort;
    int t0, t1;
    model_en = 1'b1;
    clear_logs();
    pulse_start(t0);
    repeat (41) @(posedge Clk);
    #1;
    tests_run++; if (busy !== 1'b1 || map_sel !== 1'b1 || rd_en !== 1'b0) begin tests_failed++; $display("FAIL abort_pre_drain: got busy=%0b map=%0d rd_en=%0b want 1 1 0", busy, map_sel, rd_en); end
    abort = 1'b1;
    @(posedge Clk); #1;
    abort = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %0b want 0", busy); end
    tests_run++; if (map_sel !== 1'b0) begin tests_failed++; $display("FAIL abort_map_sel: got %0d want 0", map_sel); end
    tests_run++; if (conv_valid_in !== 1'b0 || rd_en !== 1'b0) begin tests_failed++; $display("FAIL abort_feed: got valid_in=%0b rd_en=%0b want 0 0", conv_valid_in, rd_en); end
    repeat (10) @(posedge Clk);
    #1;
    tests_run++; if (wr_n !== 29) begin tests_failed++; $display("FAIL abort_wr_count: got %0d want 29", wr_n); end
    tests_run++; if (done_n !== 0) begin tests_failed++; $display("FAIL abort_done: got %0d want 0", done_n); end
    clear_logs();
    pulse_start(t1);
    repeat (50) @(posedge Clk);
    #1;
    tests_run++; if (rd_n !== 2 * PIX || wr_n !== 2 * PIX) begin tests_failed++; $display("FAIL abort_rerun_counts: got rd=%0d wr=%0d want 32 32", rd_n, wr_n); end
    tests_run++; if (done_n !== 1 || done_cyc !== t1 + 47) begin tests_failed++; $display("FAIL abort_rerun_done: got n=%0d cyc=%0d want 1 47", done_n, done_cyc - t1); end
    tests_run++; if (wr_n > 31 && (wr_log[31] !== 4'd15 || wr_map[31] !== 1'b1)) begin tests_failed++; $display("FAIL abort_rerun_last_wr: got addr=%0d map=%0d want 15 1", wr_log[31], wr_map[31]); end
  endtask

  task automatic test_reset_mid_feed;
    int t0;
    model_en = 1'b1;
    clear_logs();
    pulse_start(t0);
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    tests_run++; if (rd_en !== 1'b0 || rd_addr !== 4'd0) begin tests_failed++; $display("FAIL rst_mid_rd: got en=%0b addr=%0d want 0 0", rd_en, rd_addr); end
    tests_run++; if (conv_valid_in !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid_in: got %0b want 0", conv_valid_in); end
    tests_run++; if (wr_en !== 1'b0 || wr_addr !== 4'd0) begin tests_failed++; $display("FAIL rst_mid_wr: got en=%0b addr=%0d want 0 0", wr_en, wr_addr); end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0 || map_sel !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_status: got busy=%0b done=%0b map=%0d want 0 0 0", busy, done, map_sel); end
    @(posedge Clk); #1;
    Rst = 1'b1;
    model_en = 1'b0;
    manual_vo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      tests_run++; if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL idle_vo_wr_en_%0d: got %0b want 0", i, wr_en); end
    end
    manual_vo = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    tests_run++; if (done_n !== 0) begin tests_failed++; $display("FAIL rst_mid_done: got %0d want 0", done_n); end
  endtask

  task automatic test_extra_pulses;
    int t0;
    model_en = 1'b0;
    clear_logs();
    @(posedge Clk); #1;
    start = 1'b1;
    stall = 1'b1;
    t0 = cyc;
    @(posedge Clk); #1;
    start = 1'b0;
    manual_vo = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 9) stall = 1'b0;
      @(posedge Clk); #1;
    end
    manual_vo = 1'b0;
    tests_run++; if (map_sel !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL extra_still_map0: got map=%0d busy=%0b want 0 1", map_sel, busy); end
    abort = 1'b1;
    @(posedge Clk); #1;
    abort = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    tests_run++; if (wr_n !== PIX) begin tests_failed++; $display("FAIL extra_wr_count: got %0d want %0d", wr_n, PIX); end
    for (int i = 0; i < PIX && i < wr_n; i++) begin
      tests_run++; if (wr_log[i] !== AW'(i) || wr_map[i] !== 1'b0) begin tests_failed++; $display("FAIL extra_wr_%0d: got addr=%0d map=%0d want %0d 0", i, wr_log[i], wr_map[i], i); end
    end
    tests_run++; if (done_n !== 0) begin tests_failed++; $display("FAIL extra_done: got %0d want 0", done_n); end
    model_en = 1'b1;
  endtask

  task automatic test_double_start;
    int t0;
    model_en = 1'b1;
    clear_logs();
    pulse_start(t0);
    repeat (4) @(posedge Clk);
    #1;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (24) @(posedge Clk);
    #1;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (30) @(posedge Clk);
    #1;
    tests_run++; if (rd_n !== 2 * PIX || wr_n !== 2 * PIX) begin tests_failed++; $display("FAIL dbl_counts: got rd=%0d wr=%0d want 32 32", rd_n, wr_n); end
    for (int i = 0; i < 2 * PIX && i < wr_n; i++) begin
      tests_run++; if (wr_log[i] !== AW'(i % PIX) || wr_map[i] !== MW'(i / PIX)) begin tests_failed++; $display("FAIL dbl_wr_%0d: got addr=%0d map=%0d want %0d %0d", i, wr_log[i], wr_map[i], i % PIX, i / PIX); end
    end
    tests_run++; if (done_n !== 1) begin tests_failed++; $display("FAIL dbl_done_count: got %0d want 1", done_n); end
    tests_run++; if (done_cyc !== t0 + 47) begin tests_failed++; $display("FAIL dbl_done_cycle: got %0d want 47", done_cyc - t0); end
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_stall();
    test_abort();
    test_reset_mid_feed();
    test_extra_pulses();
    test_double_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
